uart_rx_ctrl: RTL

- 8N1 UART receiver; the receive-side counterpart of the team's UART_TX_CTRL transmitter. Same bit timing (CLKS_PER_BIT clocks per bit, LSB first, start=0, stop=1).
- Synchronises the asynchronous serial line, detects the start edge, and samples each bit at mid-bit.
- Delivers each received byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the consumer logic. The consumer has no backpressure; it must capture data on the valid strobe.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_state_e  receiver FSM state encoding
//   DATA_BITS     payload bits per frame
//   CLKS_PER_BIT_DEF  default bit period in clocks (100 MHz / 9600 baud)
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 10416;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4,
    PARITY = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
//   clk  system clock
//   rst  asynchronous active-high reset, loads RST_VAL into both flops
//   d_i  asynchronous input
//   q_o  synchronised output (2 clocks latency)
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
//   clk        system clock
//   rst        asynchronous active-high reset
//   UART_RX    raw serial line, idle high, asynchronous to clk
//   data       last correctly framed byte, held until the next good frame
//   valid      one-cycle pulse, data updated this cycle
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high whenever the FSM is not IDLE
//   parity_err (UART_RX_PARITY_EN only) pulse alongside valid on even-parity mismatch
// Bits are sampled at mid-bit: START waits HALF_BIT, then every full bit period.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TMR_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [TMR_W-1:0] HALF_END = TMR_W'(HALF_BIT - 1);
  localparam logic [TMR_W-1:0] BIT_END  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_e          state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 pbad_q, pbad_d;   // parity mismatch of the current frame
  logic                 perr_q, perr_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (UART_RX),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TMR_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; a short low pulse is dropped silently.
        if (timer_q == HALF_END) begin
          timer_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == IDX_END) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          pbad_d  = rx_s ^ (^shift_q);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            perr_d  = pbad_q;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        // Held-low line: stay here until it returns high, so a break is not
        // decoded as a stream of 0x00 frames.
        timer_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    data      = data_q;
    valid     = valid_q;
    frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    parity_err = perr_q;
`endif
  end

endmodule
